sawtooth_phase_counter: RTL and testbench
=========================================

Name: sawtooth_phase_counter

Overview:
- Phase-accumulator sawtooth source that drives the counter_value/next_counter_value_strobe interface consumed by the wave-shaping blocks (e.g. triangle generation).
- Produces a signed Q0.N_FRAC ramp at a programmable sample rate (prescaler) and frequency (increment word).
- Increment updates are glitch-free: a new frequency word takes effect only at an accumulator wrap.

Parameters:
- N_FRAC, 7: fractional bits of the Q0.N_FRAC output; output width is N_FRAC+1.
- ACC_EXTRA, 8: extra low-order accumulator bits for frequency resolution; accumulator width W = N_FRAC+1+ACC_EXTRA (16 at defaults).
- PRESCALE_W, 16: width of the sample-rate prescaler.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset, asynchronous, active-low.
- enable_i  in  1  run request; low = idle, accumulator cleared.
- prescale_i  in  PRESCALE_W  sample period minus one, in clk_i cycles.
- freq_word_i  in  W  phase increment per sample, unsigned.
- freq_load_strobe_i  in  1  one-cycle pulse that captures freq_word_i.
- counter_value_o  out  N_FRAC+1 signed  top N_FRAC+1 accumulator bits.
- next_counter_value_strobe_o  out  1  one-cycle pulse marking a new counter_value_o.
- wrap_strobe_o  out  1  one-cycle pulse: this sample's addition carried out of bit W-1.
- freq_pending_o  out  1  a loaded word is waiting for the next wrap.

Behaviour:
- Reset (rst_i=0, asynchronous):
  - All registers cleared: state=IDLE, accumulator=0, increment=0, shadow=0, pending=0, prescaler=0.
  - All outputs 0, effective immediately without waiting for a clock edge.
- FSM states:
  - IDLE: prescaler and accumulator held at 0; no strobes; counter_value_o=0.
  - RUN: samples generated as described below.
- Transitions:
  - IDLE->RUN when enable_i=1.
  - RUN->IDLE when enable_i=0. The accumulator and counter_value_o clear to 0 on that edge, and no strobe is issued in that cycle.
- Prescaler (RUN only):
  - Counts 0..prescale_i; tick when count==prescale_i, then count returns to 0.
  - prescale_i=0 gives a tick every cycle.
  - If prescale_i changes below the current count, the next compare is count>=prescale_i. That forces a tick and restart, so there is no 2^PRESCALE_W stall.
- Sample on a tick:
  - acc_next = acc + inc, modulo 2^W; carry = carry-out of the addition.
  - On the following edge: acc<=acc_next; counter_value_o<=acc_next[W-1:W-N_FRAC-1]; next_counter_value_strobe_o<=1; wrap_strobe_o<=carry.
  - Latency: tick cycle +1. All three outputs are registered and coincide.
- First sample after entering RUN is 0+inc; the tick occurs prescale_i+1 cycles after the RUN edge.
- Output format:
  - Raw two's-complement view of the accumulator MSBs.
  - Sequence 0 .. +max, -min .. -1, then wrap to 0.
  - The sign bit toggles twice per period, which is what downstream sign-change detection expects.
- Frequency load:
  - freq_load_strobe_i=1 writes freq_word_i into the shadow register and sets pending=1.
  - A later load before a wrap overwrites the shadow (last write wins).
- Applying the shadow word:
  - In IDLE, or in RUN while inc==0, the shadow is copied to inc on the next edge and pending clears.
  - In RUN otherwise, the copy happens on the edge of a sample whose carry=1; that sample itself used the old inc.
  - If a load coincides with a wrap sample, the wrap applies the previous shadow value, the new word goes into the shadow, and pending stays 1.
- freq_word = 0 is legal: the accumulator freezes, strobes continue at the sample rate, and wrap_strobe_o stays 0.
- No combinational paths from inputs to outputs.

Decomposition:
- Shared package holds:
  - state localparams IDLE=1'b0, RUN=1'b1;
  - the W derivation function/constant;
  - a zero-value constant for the Q0.N_FRAC type.
- Sub-module strobe_prescaler (clk_i, rst_i, enable_i, prescale_i -> tick_o) holds the prescaler counter.
- Accumulator, shadow/pending logic and the FSM stay in the top.

Test Plan:
- Reset/basic rate: release reset, enable=1, prescale=0, load 0x0100 while idle -> strobe every cycle; counter_value_o steps 1,2,..,127,-128,..,-1,0; wrap_strobe_o high only on the sample showing 0 (the 256th).
- Prescaler: prescale=3, inc=0x0100 -> strobes exactly 4 cycles apart; first strobe 5 cycles after enable rises.
- Glitch-free load: running at inc=0x0100, load 0x0400 when counter_value_o=10 -> freq_pending_o=1; steps stay +1 up to the wrap sample (value 0), then subsequent values are 4,8,12; pending clears on the wrap edge.
- Load collides with wrap: shadow=0x0200 pending, assert a load of 0x0800 on the wrap tick cycle -> next samples step by 2 and pending stays 1; the next wrap switches to steps of 8.
- Enable drop: enable=0 mid-ramp at value 50 -> the next edge shows counter_value_o=0 and no strobe; re-enable -> the ramp restarts at inc>>ACC_EXTRA.
- Async reset mid-run: pull rst_i low between clock edges -> all outputs 0 before the next edge; after release the block is idle with inc=0 until a load.

Source files
------------

// File: rtl/sawtooth_phase_counter_pkg.sv
// Shared types and constants for the sawtooth phase-accumulator source.
package sawtooth_phase_counter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int unsigned N_FRAC_DEF = 7;

  typedef logic signed [N_FRAC_DEF:0] q0_t;

  localparam q0_t Q0_ZERO = '0;

  function automatic int unsigned acc_width(input int unsigned n_frac,
                                            input int unsigned acc_extra);
    return n_frac + 1 + acc_extra;
  endfunction

endpackage

// File: rtl/sawtooth_phase_counter_prescaler.sv
// Sample-rate prescaler: ticks once every prescale_i+1 enabled cycles.
module strobe_prescaler #(
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  output logic                  tick_o
);

  logic [PRESCALE_W-1:0] count;

  // >= rather than == so a period shortened below the running count restarts at once
  always_comb tick_o = enable_i && (count >= prescale_i);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      count <= '0;
    end else if (!enable_i || tick_o) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/sawtooth_phase_counter.sv
// Phase-accumulator sawtooth source with prescaled sample rate and wrap-synchronous frequency update.
module sawtooth_phase_counter
  import sawtooth_phase_counter_pkg::*;
#(
  parameter int unsigned N_FRAC     = 7,
  parameter int unsigned ACC_EXTRA  = 8,
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        enable_i,
  input  logic [PRESCALE_W-1:0]       prescale_i,
  input  logic [N_FRAC+ACC_EXTRA:0]   freq_word_i,
  input  logic                        freq_load_strobe_i,
  output logic signed [N_FRAC:0]      counter_value_o,
  output logic                        next_counter_value_strobe_o,
  output logic                        wrap_strobe_o,
  output logic                        freq_pending_o
);

  localparam int unsigned W = acc_width(N_FRAC, ACC_EXTRA);

  state_e         state, state_n;
  logic [W-1:0]   acc;
  logic [W-1:0]   inc;
  logic [W-1:0]   shadow;
  logic [W:0]     sum;
  logic           run;
  logic           tick;
  logic           sample;
  logic           carry;
  logic           apply;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (enable_i)  state_n = RUN;
      RUN:     if (!enable_i) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    run    = (state == RUN) && enable_i;
    sample = run && tick;
    sum    = {1'b0, acc} + {1'b0, inc};
    carry  = sum[W];
    // A stalled accumulator (idle or zero increment) has no wrap to wait for
    apply  = (state == IDLE) || (inc == '0) || (sample && carry);
  end

  strobe_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .enable_i   (run),
    .prescale_i (prescale_i),
    .tick_o     (tick)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      acc                         <= '0;
      inc                         <= '0;
      shadow                      <= '0;
      freq_pending_o              <= 1'b0;
      counter_value_o             <= '0;
      next_counter_value_strobe_o <= 1'b0;
      wrap_strobe_o               <= 1'b0;
    end else begin
      next_counter_value_strobe_o <= 1'b0;
      wrap_strobe_o               <= 1'b0;

      if (!run) begin
        acc             <= '0;
        counter_value_o <= '0;
      end else if (sample) begin
        acc                         <= sum[W-1:0];
        counter_value_o             <= sum[W-1 -: N_FRAC+1];
        next_counter_value_strobe_o <= 1'b1;
        wrap_strobe_o               <= carry;
      end

      // A load landing on an apply edge still goes to the shadow and stays pending
      if (apply && freq_pending_o) inc <= shadow;

      if (freq_load_strobe_i) begin
        shadow         <= freq_word_i;
        freq_pending_o <= 1'b1;
      end else if (apply) begin
        freq_pending_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sawtooth_phase_counter.sv
// Self-checking bench for sawtooth_phase_counter: vector table plus scoreboarded corner sequences.
module tb_sawtooth_phase_counter;

  logic               clk = 1'b0;
  logic               rst_i;
  logic               enable_i;
  logic [15:0]        prescale_i;
  logic [15:0]        freq_word_i;
  logic               freq_load_strobe_i;
  logic signed [7:0]  cv;
  logic               nstr;
  logic               wstr;
  logic               pend;

  sawtooth_phase_counter #(
    .N_FRAC     (7),
    .ACC_EXTRA  (8),
    .PRESCALE_W (16)
  ) dut (
    .clk_i                       (clk),
    .rst_i                       (rst_i),
    .enable_i                    (enable_i),
    .prescale_i                  (prescale_i),
    .freq_word_i                 (freq_word_i),
    .freq_load_strobe_i          (freq_load_strobe_i),
    .counter_value_o             (cv),
    .next_counter_value_strobe_o (nstr),
    .wrap_strobe_o               (wstr),
    .freq_pending_o              (pend)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cv;
    int          wr;
    int unsigned cyc;
  } exp_t;

  typedef struct {
    int unsigned ps;
    int unsigned word;
    int unsigned run;
    int unsigned first;
    int unsigned gap;
    int          cv0;
    int          n;
  } vec_t;

  exp_t        sb[$];
  exp_t        mon_e;
  vec_t        vecs[6];
  int          checks    = 0;
  int          failures  = 0;
  int          n_strobes = 0;
  int unsigned cyc       = 0;
  int unsigned c0, c1;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int exp_cv(input int unsigned inc, input int unsigned k);
    longint unsigned a;
    logic signed [7:0] b;
    a = longint'(k + 1) * longint'(inc);
    b = a[15:8];
    return int'(b);
  endfunction

  function automatic int exp_wr(input int unsigned inc, input int unsigned k);
    longint unsigned a0, a1;
    a0 = longint'(k) * longint'(inc);
    a1 = longint'(k + 1) * longint'(inc);
    return ((a1 >> 16) != (a0 >> 16)) ? 1 : 0;
  endfunction

  task automatic push_seg(input int unsigned inc, input int unsigned n,
                          input int unsigned c_first, input int unsigned gap);
    exp_t e;
    for (int unsigned k = 0; k < n; k++) begin
      e.cv  = exp_cv(inc, k);
      e.wr  = exp_wr(inc, k);
      e.cyc = c_first + k * gap;
      sb.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (nstr === 1'b1) begin
      n_strobes++;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_strobe: got strobe cv=%0d at cycle %0d expected none", cv, cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("sample_value", int'(cv), mon_e.cv);
        chk("sample_wrap", int'(wstr), mon_e.wr);
        chk("sample_cycle", int'(cyc), int'(mon_e.cyc));
      end
    end else if (wstr !== 1'b0) begin
      chk("wrap_without_strobe", int'(wstr), 0);
    end
  end

  task automatic wait_cyc(input int unsigned t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic load_word(input int unsigned w);
    freq_word_i        = w[15:0];
    freq_load_strobe_i = 1'b1;
    @(negedge clk);
    freq_load_strobe_i = 1'b0;
    chk("load_pending", int'(pend), 1);
  endtask

  task automatic idle_load(input int unsigned w);
    load_word(w);
    @(negedge clk);
    chk("idle_apply_pending", int'(pend), 0);
  endtask

  task automatic go_idle();
    enable_i = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic drain();
    repeat (2) @(negedge clk);
    chk("sb_drain", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    //           ps  word     run  first gap cv0  n
    vecs[0] = '{0, 'h0100, 257, 2,    1,   1, 256};
    vecs[1] = '{3, 'h0100, 14,  5,    4,   1, 3};
    vecs[2] = '{1, 'h0300, 8,   3,    2,   3, 3};
    vecs[3] = '{0, 'h0000, 5,   2,    1,   0, 4};
    vecs[4] = '{2, 'h0080, 11,  4,    3,   0, 3};
    vecs[5] = '{0, 'hFF00, 4,   2,    1,  -1, 3};

    rst_i              = 1'b0;
    enable_i           = 1'b0;
    prescale_i         = '0;
    freq_word_i        = '0;
    freq_load_strobe_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_cv", int'(cv), 0);
    chk("reset_strobe", int'(nstr), 0);
    chk("reset_wrap", int'(wstr), 0);
    chk("reset_pending", int'(pend), 0);
    rst_i = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      go_idle();
      prescale_i = vecs[i].ps[15:0];
      idle_load(vecs[i].word);
      c0        = cyc;
      n_strobes = 0;
      for (int unsigned k = 0; vecs[i].first + k * vecs[i].gap <= vecs[i].run; k++) begin
        e.cv  = (k == 0) ? vecs[i].cv0 : exp_cv(vecs[i].word, k);
        e.wr  = exp_wr(vecs[i].word, k);
        e.cyc = c0 + vecs[i].first + k * vecs[i].gap;
        sb.push_back(e);
      end
      enable_i = 1'b1;
      wait_cyc(c0 + vecs[i].run);
      enable_i = 1'b0;
      drain();
      chk("strobe_count", n_strobes, vecs[i].n);
    end

    // glitch-free load: new word waits for the wrap
    go_idle();
    prescale_i = '0;
    idle_load('h0100);
    c0 = cyc;
    push_seg('h0100, 256, c0 + 2, 1);
    push_seg('h0400, 3, c0 + 258, 1);
    enable_i = 1'b1;
    wait_cyc(c0 + 11);
    load_word('h0400);
    wait_cyc(c0 + 256);
    chk("pending_before_wrap", int'(pend), 1);
    wait_cyc(c0 + 257);
    chk("pending_after_wrap", int'(pend), 0);
    wait_cyc(c0 + 260);
    enable_i = 1'b0;
    drain();

    // load collides with the wrap sample
    go_idle();
    idle_load('h0100);
    c0 = cyc;
    push_seg('h0100, 256, c0 + 2, 1);
    push_seg('h0200, 128, c0 + 258, 1);
    push_seg('h0800, 3, c0 + 386, 1);
    enable_i = 1'b1;
    wait_cyc(c0 + 6);
    load_word('h0200);
    wait_cyc(c0 + 256);
    load_word('h0800);
    wait_cyc(c0 + 384);
    chk("collide_pending_held", int'(pend), 1);
    wait_cyc(c0 + 385);
    chk("collide_pending_clear", int'(pend), 0);
    wait_cyc(c0 + 388);
    enable_i = 1'b0;
    drain();

    // enable drop mid-ramp, then restart
    go_idle();
    idle_load('h0100);
    c0 = cyc;
    push_seg('h0100, 50, c0 + 2, 1);
    enable_i = 1'b1;
    wait_cyc(c0 + 51);
    enable_i = 1'b0;
    @(negedge clk);
    chk("disable_cv", int'(cv), 0);
    chk("disable_strobe", int'(nstr), 0);
    c1 = cyc;
    push_seg('h0100, 1, c1 + 2, 1);
    enable_i = 1'b1;
    wait_cyc(c1 + 2);
    enable_i = 1'b0;
    drain();

    // prescale reduced below the running count
    go_idle();
    prescale_i = 16'd7;
    c0 = cyc;
    push_seg('h0100, 3, c0 + 6, 2);
    enable_i = 1'b1;
    wait_cyc(c0 + 5);
    prescale_i = 16'd1;
    wait_cyc(c0 + 10);
    enable_i = 1'b0;
    drain();

    // asynchronous reset between clock edges
    prescale_i = '0;
    c0 = cyc;
    push_seg('h0100, 20, c0 + 2, 1);
    enable_i = 1'b1;
    wait_cyc(c0 + 6);
    load_word('h0300);
    wait_cyc(c0 + 21);
    #2;
    rst_i = 1'b0;
    #1;
    chk("async_rst_cv", int'(cv), 0);
    chk("async_rst_strobe", int'(nstr), 0);
    chk("async_rst_wrap", int'(wstr), 0);
    chk("async_rst_pending", int'(pend), 0);
    enable_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_i = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_pending", int'(pend), 0);
    c1 = cyc;
    push_seg(0, 3, c1 + 2, 1);
    enable_i = 1'b1;
    wait_cyc(c1 + 4);
    enable_i = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
